// File: rtl/snitch_wb_arbiter_if.sv
// Writeback arbiter bus: producer issue, per-source writeback requests,
// regfile write port and scoreboard hazard-check lookups.
interface snitch_wb_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NR_SOURCES = 3,
    parameter int unsigned NR_CHECKS  = 3
);
    logic                                    issue_valid_i;
    logic [ADDR_WIDTH-1:0]                   issue_rd_i;
    logic [NR_SOURCES-1:0]                   src_valid_i;
    logic [NR_SOURCES-1:0]                   src_ready_o;
    logic [NR_SOURCES-1:0][ADDR_WIDTH-1:0]   src_rd_i;
    logic [NR_SOURCES-1:0][DATA_WIDTH-1:0]   src_data_i;
    logic [ADDR_WIDTH-1:0]                   waddr_o;
    logic [DATA_WIDTH-1:0]                   wdata_o;
    logic                                    we_o;
    logic [NR_CHECKS-1:0][ADDR_WIDTH-1:0]    chk_addr_i;
    logic [NR_CHECKS-1:0]                    chk_busy_o;
    logic [(2**ADDR_WIDTH)-1:0]              busy_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, src_valid_i, src_rd_i, src_data_i, chk_addr_i,
        output src_ready_o, waddr_o, wdata_o, we_o, chk_busy_o, busy_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, src_valid_i, src_rd_i, src_data_i, chk_addr_i,
        input  src_ready_o, waddr_o, wdata_o, we_o, chk_busy_o, busy_o
    );
endinterface

// File: rtl/snitch_wb_arbiter.sv
// Round-robin writeback arbiter with a 1-cycle registered regfile write port
// and a pending-write scoreboard for hazard checks.
module snitch_wb_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned NR_SOURCES    = 3,
    parameter int unsigned NR_CHECKS     = 3,
    parameter bit          ZERO_REG_ZERO = 1'b1
) (
    input logic                clk_i,
    input logic                rst_i,
    snitch_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_WIDTH = $clog2(NR_SOURCES);
    localparam int unsigned NR_REGS   = 2**ADDR_WIDTH;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // Source index 'off' positions after 'base', wrapping at NR_SOURCES.
    function automatic ptr_t wrap_add(input int unsigned base, input int unsigned off);
        return ptr_t'((base + off) % NR_SOURCES);
    endfunction

    ptr_t                  rr_ptr_q;
    ptr_t                  gnt_idx;
    logic                  gnt_found;
    logic [NR_SOURCES-1:0] gnt;
    logic                  xfer;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] xfer_rd;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic [NR_REGS-1:0]    busy_q;
    logic [NR_REGS-1:0]    busy_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // rr_ptr_q names the source with highest priority this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 0; i < NR_SOURCES; i++) begin
            if (!gnt_found && bus.src_valid_i[wrap_add(32'(rr_ptr_q), i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(32'(rr_ptr_q), i);
            end
        end
        gnt[gnt_idx] = gnt_found;
    end

    assign bus.src_ready_o = rst_i ? '0 : gnt;
    assign xfer            = gnt_found & ~rst_i;
    assign xfer_rd         = bus.src_rd_i[gnt_idx];
    assign xfer_data       = bus.src_data_i[gnt_idx];
    // Writes to the hardwired-zero register are accepted but dropped.
    assign wr_en           = xfer & ~(ZERO_REG_ZERO && (xfer_rd == '0));

    // Clear on writeback first, then set on issue so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[xfer_rd] = 1'b0;
        end
        if (bus.issue_valid_i) begin
            busy_d[bus.issue_rd_i] = 1'b1;
        end
        if (ZERO_REG_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= wr_en;
            if (wr_en) begin
                waddr_q <= xfer_rd;
                wdata_q <= xfer_data;
            end
            if (xfer) begin
                rr_ptr_q <= wrap_add(32'(gnt_idx), 1);
            end
        end
    end

    // Hazard lookups see only the registered scoreboard, never this cycle's updates.
    always_comb begin
        bus.chk_busy_o = '0;
        for (int unsigned i = 0; i < NR_CHECKS; i++) begin
            bus.chk_busy_o[i] = busy_q[bus.chk_addr_i[i]];
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.we_o    = we_q;
    assign bus.waddr_o = waddr_q;
    assign bus.wdata_o = wdata_q;
endmodule

// File: tb/tb_snitch_wb_arbiter.sv
// Directed bench for snitch_wb_arbiter: an abstract per-cycle model checked on
// every negative edge, plus hand-computed expectations for the key scenarios.
module tb_snitch_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int NC = 3;
    localparam int NR = 2**AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snitch_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_SOURCES(NS), .NR_CHECKS(NC)) bus ();

    snitch_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_SOURCES(NS), .NR_CHECKS(NC), .ZERO_REG_ZERO(1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: priority index, pending-register set, last regfile write.
    int          m_ptr     = 0;
    bit [NR-1:0] m_busy    = '0;
    bit          m_we      = 1'b0;
    bit [AW-1:0] m_waddr   = '0;
    bit [DW-1:0] m_wdata   = '0;
    bit          m_started = 1'b0;

    // Winner: first valid source scanning from the priority index, -1 if none.
    function automatic int winner();
        if (rst) return -1;
        for (int off = 0; off < NS; off++) begin
            if (bus.src_valid_i[(m_ptr + off) % NS]) return (m_ptr + off) % NS;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int k;
        k = winner();
        if (rst) begin
            m_ptr   = 0;
            m_busy  = '0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            m_we = 1'b0;
            if (k >= 0) begin
                if (bus.src_rd_i[k] != 0) begin
                    m_we    = 1'b1;
                    m_waddr = bus.src_rd_i[k];
                    m_wdata = bus.src_data_i[k];
                end
                m_busy[bus.src_rd_i[k]] = 1'b0;
                m_ptr = (k + 1) % NS;
            end
            if (bus.issue_valid_i && bus.issue_rd_i != 0) m_busy[bus.issue_rd_i] = 1'b1;
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        int k;
        logic [NS-1:0] exp_ready;
        if (m_started) begin
            k = winner();
            exp_ready = '0;
            if (k >= 0) exp_ready[k] = 1'b1;
            check("model_ready", bus.src_ready_o, exp_ready);
            check("model_we", bus.we_o, m_we);
            check("model_waddr", bus.waddr_o, m_waddr);
            check("model_wdata", bus.wdata_o, m_wdata);
            check("model_busy", bus.busy_o, m_busy);
            for (int i = 0; i < NC; i++) begin
                check("model_chk_busy", bus.chk_busy_o[i], m_busy[bus.chk_addr_i[i]]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NS-1:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        bus.issue_valid_i = 1'b0;
        bus.issue_rd_i    = '0;
        bus.src_valid_i   = '0;
        bus.src_rd_i      = '0;
        bus.src_data_i    = '0;
        bus.chk_addr_i    = {5'd7, 5'd5, 5'd0};

        tick();
        tick();
        check("reset_busy", bus.busy_o, 0);
        check("reset_we", bus.we_o, 0);
        rst = 1'b0;

        // All three sources valid: grants rotate 0,1,2,0; writes trail by one cycle.
        bus.src_valid_i = 3'b111;
        bus.src_rd_i    = {5'd3, 5'd2, 5'd1};
        bus.src_data_i  = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", bus.src_ready_o, rr_exp[i]);
            if (i > 0) begin
                check("rr_we", bus.we_o, 1);
                check("rr_waddr", bus.waddr_o, (i - 1) % 3 + 1);
            end
            tick();
        end
        bus.src_valid_i = '0;
        #1;
        check("rr_last_waddr", bus.waddr_o, 1);
        check("rr_last_wdata", bus.wdata_o, 32'hA0A0_0001);
        tick();
        check("idle_we", bus.we_o, 0);
        check("idle_waddr_hold", bus.waddr_o, 1);

        // Issue rd=5, then source 1 writes it back three cycles later.
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd5;
        tick();
        bus.issue_valid_i = 1'b0;
        #1;
        check("issue5_busy", bus.busy_o[5], 1);
        check("issue5_chk", bus.chk_busy_o[1], 1);
        tick();
        tick();
        bus.src_valid_i = 3'b010;
        bus.src_rd_i[1]   = 5'd5;
        bus.src_data_i[1] = 32'hDEAD_BEEF;
        #1;
        check("wb5_ready", bus.src_ready_o, 3'b010);
        check("wb5_no_bypass", bus.chk_busy_o[1], 1);
        tick();
        bus.src_valid_i = '0;
        #1;
        check("wb5_busy_clr", bus.busy_o[5], 0);
        check("wb5_we", bus.we_o, 1);
        check("wb5_waddr", bus.waddr_o, 5);
        check("wb5_wdata", bus.wdata_o, 32'hDEAD_BEEF);

        // Same-cycle issue and writeback to busy rd=7: set wins.
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd7;
        tick();
        #1;
        check("issue7_busy", bus.busy_o[7], 1);
        bus.src_valid_i   = 3'b001;
        bus.src_rd_i[0]   = 5'd7;
        bus.src_data_i[0] = 32'h0000_0077;
        #1;
        check("both7_ready", bus.src_ready_o, 3'b001);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.src_valid_i   = '0;
        #1;
        check("both7_busy", bus.busy_o[7], 1);
        check("both7_we", bus.we_o, 1);
        check("both7_waddr", bus.waddr_o, 7);

        // Writeback and issue to the zero register.
        bus.src_valid_i   = 3'b010;
        bus.src_rd_i[1]   = 5'd0;
        bus.src_data_i[1] = 32'hFFFF_FFFF;
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd0;
        #1;
        check("zero_ready", bus.src_ready_o, 3'b010);
        tick();
        bus.src_valid_i   = '0;
        bus.issue_valid_i = 1'b0;
        #1;
        check("zero_we", bus.we_o, 0);
        check("zero_waddr_hold", bus.waddr_o, 7);
        check("zero_wdata_hold", bus.wdata_o, 32'h0000_0077);
        check("zero_busy0", bus.busy_o[0], 0);

        // Grant 0, then lone source 2 is served at once, then 0 beats 1.
        bus.chk_addr_i  = {5'd9, 5'd7, 5'd3};
        bus.src_valid_i = 3'b001;
        #1;
        check("skip_g0", bus.src_ready_o, 3'b001);
        tick();
        bus.src_valid_i = 3'b100;
        #1;
        check("skip_g2", bus.src_ready_o, 3'b100);
        tick();
        bus.src_valid_i = 3'b011;
        #1;
        check("skip_g0_again", bus.src_ready_o, 3'b001);
        tick();
        bus.src_valid_i = '0;

        // Reset mid-stream with pending requests and a busy register.
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd3;
        tick();
        bus.issue_valid_i = 1'b0;
        #1;
        check("pre_rst_busy3", bus.busy_o[3], 1);
        bus.src_valid_i = 3'b111;
        bus.src_rd_i    = {5'd3, 5'd2, 5'd1};
        #1;
        check("pre_rst_grant", bus.src_ready_o, 3'b010);
        tick();
        rst = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd4;
        #1;
        check("rst_ready", bus.src_ready_o, 0);
        tick();
        rst = 1'b0;
        bus.issue_valid_i = 1'b0;
        #1;
        check("post_rst_busy", bus.busy_o, 0);
        check("post_rst_we", bus.we_o, 0);
        check("post_rst_waddr", bus.waddr_o, 0);
        check("post_rst_grant", bus.src_ready_o, 3'b001);
        tick();
        bus.src_valid_i = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snitch_wb_arbiter.md
SNITCH_WB_ARBITER -- requirements
Module: snitch_wb_arbiter

Interface
REQ-001: Parameters SHALL be:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width.
- NR_SOURCES, 3, number of writeback requesters (at least 2).
- NR_CHECKS, 3, number of hazard-check ports.
- ZERO_REG_ZERO, 1, register 0 is hardwired zero.

REQ-002: Ports SHALL be:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, synchronous and active-high.
- issue_valid_i, in, 1: producer issued; mark rd pending.
- issue_rd_i, in, ADDR_WIDTH: destination of issued producer.
- src_valid_i, in, NR_SOURCES: writeback request per source.
- src_ready_o, out, NR_SOURCES: grant/accept per source.
- src_rd_i, in, NR_SOURCES x ADDR_WIDTH: destination per source.
- src_data_i, in, NR_SOURCES x DATA_WIDTH: data per source.
- waddr_o, out, ADDR_WIDTH: regfile write address.
- wdata_o, out, DATA_WIDTH: regfile write data.
- we_o, out, 1: regfile write enable.
- chk_addr_i, in, NR_CHECKS x ADDR_WIDTH: addresses to hazard-check.
- chk_busy_o, out, NR_CHECKS: address has pending write.
- busy_o, out, 2**ADDR_WIDTH: full scoreboard vector.

Function
REQ-003: Arbitration SHALL be round-robin among asserted src_valid_i; at most one src_ready_o bit is high per cycle, and only for a valid source.
REQ-004: src_ready_o SHALL be combinational from src_valid_i and the RR pointer; no dependency on we_o or downstream state (the regfile never stalls).
REQ-005: A transfer occurs when src_valid_i[k] and src_ready_o[k] are both high; sources SHALL hold rd and data stable while valid and not ready.
REQ-006: The RR pointer SHALL reset to 0, giving source 0 highest priority. After a grant to k, priority order SHALL be k+1, k+2, … modulo NR_SOURCES. The pointer SHALL be unchanged in cycles without a grant.
REQ-007: Write latency SHALL be 1 cycle: a transfer at edge t drives we_o=1 and waddr_o/wdata_o = granted rd/data registered, valid during cycle t+1.
REQ-008: we_o SHALL be 0 in any cycle following a cycle with no transfer. waddr_o and wdata_o SHALL hold their last values when we_o=0.
REQ-009: With ZERO_REG_ZERO=1, a transfer with rd=0 SHALL still be accepted (ready high), produce we_o=0, and leave the scoreboard unchanged.
REQ-010: Scoreboard: issue_valid_i SHALL set busy[issue_rd_i] at the next edge. A transfer SHALL clear busy[rd] at the next edge.
REQ-011: If issue and transfer target the same rd in the same cycle, set SHALL win and busy stays 1.
REQ-012: Issue to an already-busy register SHALL keep busy=1 (no counting). A transfer to a non-busy register SHALL be legal and leave busy=0.
REQ-013: With ZERO_REG_ZERO=1, busy[0] SHALL be constant 0 and issue to rd=0 SHALL be ignored.
REQ-014: chk_busy_o[i] SHALL equal busy_o[chk_addr_i[i]] combinationally from the registered scoreboard, with no same-cycle bypass of issue or transfer.
REQ-015: busy_o SHALL be a direct register output.

Reset
REQ-016: While rst_i=1 at a clock edge, the block SHALL clear: busy_o to all 0, we_o=0, waddr_o=0, wdata_o=0, RR pointer=0.
REQ-017: While rst_i=1, src_ready_o SHALL be all 0, and issue and transfers SHALL be ignored, including when reset is asserted mid-stream with requests pending.
REQ-018: The first cycle after rst_i deasserts SHALL behave as post-reset state with the pointer at 0.

Verification
REQ-019: All three sources valid continuously with rd=1,2,3 -> grants 0,1,2,0,… in consecutive cycles; we_o high every cycle from the second onward; waddr_o follows 1,2,3,1.
REQ-020: Issue rd=5 at cycle 0 -> busy_o[5]=1 from cycle 1; source 1 writes rd=5 with data 0xDEADBEEF at cycle 3 -> busy_o[5]=0 and we_o=1, waddr_o=5, wdata_o=0xDEADBEEF at cycle 4.
REQ-021: Same-cycle issue rd=7 and transfer rd=7 with busy[7]=1 -> busy[7] remains 1 at the next cycle; we_o=1, waddr_o=7.
REQ-022: Transfer rd=0 with data 0xFFFFFFFF -> ready=1, we_o=0 next cycle; issue rd=0 -> busy_o[0] stays 0.
REQ-023: Only source 2 valid after a grant to source 0 -> source 2 granted immediately; the pointer advances so source 0 wins next contention over source 1.
REQ-024: rst_i asserted for one cycle while sources are valid and busy_o[3]=1 -> src_ready_o=0 that cycle; afterwards busy_o=0, we_o=0, and source 0 has priority.
